// File: rtl/breath_led_ctrl.sv
// breath_led_ctrl: mode-selectable LED breathing/chase controller with PWM brightness ramp
module breath_led_ctrl #(
  parameter logic [5:0] CNT_1US_MAX = 6'd49,
  parameter logic [9:0] CNT_1MS_MAX = 10'd999,
  parameter logic [9:0] CNT_1S_MAX  = 10'd999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic       key_flag,
  output logic [3:0] led_out,
  output logic [1:0] mode,
  output logic       breath_done
);
  typedef enum logic [1:0] {IDLE = 2'd0, BREATH_ALL = 2'd1, CHASE = 2'd2, ON = 2'd3} mode_t;
  mode_t      mode_q, mode_d;
  logic [5:0] cnt_1us_q, cnt_1us_d;
  logic [9:0] cnt_1ms_q, cnt_1ms_d;
  logic [9:0] cnt_1s_q, cnt_1s_d;
  logic       phase_q, phase_d;
  logic [1:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic [3:0] led_q, led_d;
  logic       mode_chg, run, tick_1us, frame_end, s_wrap, done_evt, pwm_on;
  assign mode_chg  = en && key_flag;
  assign run       = en && (mode_q == BREATH_ALL || mode_q == CHASE);
  assign tick_1us  = cnt_1us_q == CNT_1US_MAX;
  assign frame_end = tick_1us && cnt_1ms_q == CNT_1MS_MAX;
  assign s_wrap    = frame_end && cnt_1s_q == CNT_1S_MAX;
  // a mode change on the wrap edge suppresses the breath-complete event
  assign done_evt  = run && s_wrap && phase_q && !mode_chg;
  assign pwm_on    = phase_q ? (cnt_1ms_q >= cnt_1s_q) : (cnt_1ms_q < cnt_1s_q);
  assign mode        = mode_q;
  assign led_out     = led_q;
  assign breath_done = done_q;
  // mode sequencer: each accepted key press steps to the next mode
  always_comb begin
    mode_d = mode_q;
    if (mode_chg)
      unique case (mode_q)
        IDLE:       mode_d = BREATH_ALL;
        BREATH_ALL: mode_d = CHASE;
        CHASE:      mode_d = ON;
        ON:         mode_d = IDLE;
      endcase
  end
  // timebase counters, breath phase and chase index; mode change clears, en low freezes
  always_comb begin
    cnt_1us_d = cnt_1us_q;
    cnt_1ms_d = cnt_1ms_q;
    cnt_1s_d  = cnt_1s_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    if (mode_chg) begin
      cnt_1us_d = '0;
      cnt_1ms_d = '0;
      cnt_1s_d  = '0;
      phase_d   = 1'b0;
      idx_d     = '0;
    end else if (run) begin
      cnt_1us_d = tick_1us ? '0 : cnt_1us_q + 6'd1;
      if (tick_1us) cnt_1ms_d = (cnt_1ms_q == CNT_1MS_MAX) ? '0 : cnt_1ms_q + 10'd1;
      if (frame_end) cnt_1s_d = (cnt_1s_q == CNT_1S_MAX) ? '0 : cnt_1s_q + 10'd1;
      if (s_wrap) phase_d = ~phase_q;
      if (done_evt && mode_q == CHASE) idx_d = idx_q + 2'd1;
    end
  end
  // LED pattern and done pulse, registered one cycle behind counters/mode
  always_comb begin
    done_d = done_evt;
    led_d  = !en                 ? 4'hf :
             mode_q == ON         ? 4'h0 :
             mode_q == BREATH_ALL ? {4{~pwm_on}} :
             mode_q == CHASE      ? ~({3'b000, pwm_on} << idx_q) : 4'hf;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q    <= IDLE;
      cnt_1us_q <= '0;
      cnt_1ms_q <= '0;
      cnt_1s_q  <= '0;
      phase_q   <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      led_q     <= 4'hf;
    end else begin
      mode_q    <= mode_d;
      cnt_1us_q <= cnt_1us_d;
      cnt_1ms_q <= cnt_1ms_d;
      cnt_1s_q  <= cnt_1s_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end
endmodule

// File: tb/tb_breath_led_ctrl.sv
// tb_breath_led_ctrl: directed self-checking bench for breath_led_ctrl with small timebase
module tb_breath_led_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       key = 1'b0;
  logic [3:0] led;
  logic [1:0] mode;
  logic       bd;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  breath_led_ctrl #(
    .CNT_1US_MAX(6'd4),
    .CNT_1MS_MAX(10'd9),
    .CNT_1S_MAX (10'd9)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .en         (en),
    .key_flag   (key),
    .led_out    (led),
    .mode       (mode),
    .breath_done(bd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // brightness at run-cycle m: 5 clk per us, 50 clk per frame, 500 clk per phase
  function automatic logic pwm_at(input int m);
    int us, fr, ph;
    us = (m / 5) % 10;
    fr = (m / 50) % 10;
    ph = (m / 500) % 2;
    return ph != 0 ? (us >= fr) : (us < fr);
  endfunction

  function automatic logic [3:0] chase_led(input int m);
    logic [3:0] l;
    int idx;
    idx = (m / 1000) % 4;
    l = 4'hf;
    if (pwm_at(m)) l[idx] = 1'b0;
    return l;
  endfunction

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    key = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic press(input int k);
    key = 1'b1;
    cyc(k);
    key = 1'b0;
  endtask

  initial begin
    int bad;
    cyc(2);
    chk("rst_mode", mode, 0);
    chk("rst_led", led, 4'hf);
    chk("rst_bd", bd, 0);
    rst_n = 1'b1;
    en = 1'b1;
    bad = 0;
    for (int n = 0; n < 2000; n++) begin
      cyc(1);
      if (led !== 4'hf || mode !== 2'd0 || bd !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    press(1);
    chk("breath_mode", mode, 1);
    chk("breath_led0", led, 4'hf);
    for (int n = 1; n <= 2100; n++) begin
      cyc(1);
      chk("breath_led", led, pwm_at(n - 1) ? 4'h0 : 4'hf);
      chk("breath_done", bd, (n % 1000) == 0);
    end

    do_reset();
    press(3);
    chk("on_mode", mode, 3);
    cyc(1);
    chk("on_led", led, 4'h0);
    press(1);
    chk("idle_mode", mode, 0);
    chk("idle_led_lag", led, 4'h0);
    cyc(1);
    chk("idle_led", led, 4'hf);

    do_reset();
    press(2);
    chk("chase_mode", mode, 2);
    chk("chase_led0", led, 4'hf);
    for (int n = 1; n <= 4100; n++) begin
      cyc(1);
      chk("chase_led", led, chase_led(n - 1));
      chk("chase_done", bd, (n % 1000) == 0);
    end
    chk("chase_mode_end", mode, 2);

    do_reset();
    press(2);
    cyc(700);
    en = 1'b0;
    cyc(100);
    chk("pause_led", led, 4'hf);
    key = 1'b1;
    cyc(1);
    key = 1'b0;
    cyc(199);
    chk("pause_mode", mode, 2);
    chk("pause_led_end", led, 4'hf);
    chk("pause_no_done", bd, 0);
    en = 1'b1;
    for (int n = 1001; n <= 1310; n++) begin
      cyc(1);
      chk("resume_led", led, chase_led(n - 301));
      chk("resume_done", bd, n == 1300);
    end
    chk("resume_mode", mode, 2);

    do_reset();
    press(2);
    cyc(999);
    key = 1'b1;
    cyc(1);
    key = 1'b0;
    chk("wrapkey_mode", mode, 3);
    chk("wrapkey_no_done", bd, 0);
    cyc(1);
    chk("wrapkey_led", led, 4'h0);
    chk("wrapkey_no_done2", bd, 0);
    press(1);
    press(1);
    chk("rst_pre_mode", mode, 1);
    cyc(274);
    chk("rst_pre_led", led, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mode", mode, 0);
    chk("async_rst_led", led, 4'hf);
    chk("async_rst_bd", bd, 0);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      cyc(1);
      if (led !== 4'hf || mode !== 2'd0 || bd !== 1'b0) bad++;
    end
    chk("rst_hold_bad_cycles", bad, 0);
    rst_n = 1'b1;
    key = 1'b1;
    cyc(1);
    key = 1'b0;
    chk("first_key_mode", mode, 1);
    for (int n = 1; n <= 1001; n++) begin
      cyc(1);
      chk("post_rst_led", led, pwm_at(n - 1) ? 4'h0 : 4'hf);
      chk("post_rst_done", bd, n == 1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
